// File: rtl/pim_job_arbiter.sv
// Round-robin scheduler that shares one PIM matrix-multiply unit among NUM_REQ requesters,
// issuing one job at a time, returning a per-owner completion pulse, and retiring hung jobs via a watchdog.
module pim_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_src1_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_src2_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_dst_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          done_valid,
  output logic                        done_err,
  output logic                        mem_start,
  output logic [ADDR_W-1:0]           mem_src1_addr,
  output logic [ADDR_W-1:0]           mem_src2_addr,
  output logic [ADDR_W-1:0]           mem_dst_addr,
  input  logic                        mem_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

  state_t             state_q;
  logic [IDW-1:0]     rrPtr_q;
  logic [IDW-1:0]     grantId_q;
  logic [WDW-1:0]     wdCnt_q;
  logic [ADDR_W-1:0]  src1_q;
  logic [ADDR_W-1:0]  src2_q;
  logic [ADDR_W-1:0]  dst_q;
  logic               memStart_q;
  logic               doneErr_q;
  logic [NUM_REQ-1:0] doneValid_q;

  logic [IDW-1:0]     pickId_d;
  logic               pickFound_d;
  logic [IDW-1:0]     cand;
  int                 candSum;
  logic               wdExpired;

  logic [ADDR_W-1:0]  src1Arr [NUM_REQ];
  logic [ADDR_W-1:0]  src2Arr [NUM_REQ];
  logic [ADDR_W-1:0]  dstArr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign src1Arr[g] = req_src1_addr[g*ADDR_W +: ADDR_W];
    assign src2Arr[g] = req_src2_addr[g*ADDR_W +: ADDR_W];
    assign dstArr[g]  = req_dst_addr[g*ADDR_W +: ADDR_W];
  end

  // First valid requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pickId_d    = '0;
    pickFound_d = 1'b0;
    candSum     = 0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = int'(rrPtr_q) + k;
      if (candSum >= NUM_REQ) candSum = candSum - NUM_REQ;
      cand = IDW'(candSum);
      if (!pickFound_d && req_valid[cand]) begin
        pickFound_d = 1'b1;
        pickId_d    = cand;
      end
    end
  end

  assign wdExpired = (TIMEOUT != 0) && (wdCnt_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rrPtr_q     <= '0;
      grantId_q   <= '0;
      wdCnt_q     <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      dst_q       <= '0;
      memStart_q  <= 1'b0;
      doneErr_q   <= 1'b0;
      doneValid_q <= '0;
    end else begin
      memStart_q  <= 1'b0;
      doneErr_q   <= 1'b0;
      doneValid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pickFound_d) begin
            grantId_q  <= pickId_d;
            src1_q     <= src1Arr[pickId_d];
            src2_q     <= src2Arr[pickId_d];
            dst_q      <= dstArr[pickId_d];
            memStart_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdCnt_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdCnt_q <= wdCnt_q + WDW'(1);
          // A real completion in the expiry cycle still counts as success.
          if (mem_done || wdExpired) begin
            doneValid_q <= NUM_REQ'(1) << grantId_q;
            doneErr_q   <= !mem_done;
            state_q     <= S_RETIRE;
          end
        end
        S_RETIRE: begin
          rrPtr_q <= (grantId_q == IDW'(NUM_REQ - 1)) ? '0 : grantId_q + IDW'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE && pickFound_d && !rst) ? (NUM_REQ'(1) << pickId_d) : '0;
  assign done_valid    = doneValid_q;
  assign done_err      = doneErr_q;
  assign mem_start     = memStart_q;
  assign mem_src1_addr = src1_q;
  assign mem_src2_addr = src2_q;
  assign mem_dst_addr  = dst_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grantId_q;

endmodule
